// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller
// Contents: FSM state encoding, counter width, PCSrc encodings, the control-output
// bundle with its canned values, and the load-use detection helper.
package pipeline_hazard_ctrl_pkg;

    localparam int CNT_W = 16;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'd0,
        PCSRC_BRANCH = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_JR     = 2'd3
    } pcsrc_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_cont;
        logic if_id_flush;
        logic id_ex_flush;
        logic id_ex_hold;
        logic ex_mem_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = ctrl_t'(6'b100000);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b010011);
    localparam ctrl_t CTRL_BRANCH = ctrl_t'(6'b101100);
    localparam ctrl_t CTRL_STALL  = ctrl_t'(6'b010100);
    localparam ctrl_t CTRL_JUMP   = ctrl_t'(6'b101000);

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return mem_read && (ex_rt != '0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
// Ports: clk, reset (async, active-high), inc (count enable), count (current value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze control for a 5-stage pipeline
// Inputs : clk, reset (async, active-high), ID_rs/ID_rt/ID_uses_rt (ID sources),
//          EX_MemRead/EX_rt (load in EX), ID_jump, EX_branch_taken,
//          mem_req/mem_ready (data-memory handshake in MEM).
// Outputs: PCWrite, IF_IDCont (1 = IF_ID holds), IF_ID_Flush, ID_EX_Flush,
//          ID_EX_Hold, EX_MEM_Hold, stall_cnt/flush_cnt (saturating), timeout_err.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_rt,
    input  logic             ID_jump,
    input  logic             EX_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IF_IDCont,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_wait;
    logic             mem_stall, freeze, load_use, stall_inc, flush_inc;
    ctrl_t            ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
        end
    end

    assign mem_stall = mem_req && !mem_ready;

    // The wait counter holds the number of completed MEM_WAIT cycles; the
    // cycle that brings it to MAX_WAIT without mem_ready is the last one.
    always_comb begin
        next_state = state;
        next_wait  = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    next_state = ST_MEM_WAIT;
                    next_wait  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready)
                    next_state = ST_RUN;
                else begin
                    next_wait = wait_cnt + CNT_W'(1);
                    if (wait_cnt == CNT_W'(MAX_WAIT - 1))
                        next_state = ST_TIMEOUT;
                end
            end
            default: next_state = ST_TIMEOUT;
        endcase
    end

    assign freeze   = mem_stall || (state == ST_TIMEOUT);
    assign load_use = load_use_hit(EX_MemRead, EX_rt, ID_rs, ID_rt, ID_uses_rt);

    // Reset overrides everything so no freeze leaks out while the state is clearing.
    always_comb begin
        ctrl = reset           ? CTRL_NORMAL :
               freeze          ? CTRL_FREEZE :
               EX_branch_taken ? CTRL_BRANCH :
               load_use        ? CTRL_STALL  :
               ID_jump         ? CTRL_JUMP   : CTRL_NORMAL;
    end

    assign PCWrite     = ctrl.pc_write;
    assign IF_IDCont   = ctrl.if_id_cont;
    assign IF_ID_Flush = ctrl.if_id_flush;
    assign ID_EX_Flush = ctrl.id_ex_flush;
    assign ID_EX_Hold  = ctrl.id_ex_hold;
    assign EX_MEM_Hold = ctrl.ex_mem_hold;
    assign timeout_err = (state == ST_TIMEOUT);

    // A taken branch squashes the load-use stall, so only an unshadowed load-use counts.
    assign stall_inc = freeze || (load_use && !EX_branch_taken);
    assign flush_inc = ctrl.if_id_flush || ctrl.id_ex_flush;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: self-checking bench for pipeline_hazard_ctrl (MAX_WAIT = 4)
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ID_rs = '0, ID_rt = '0, EX_rt = '0;
    logic        ID_uses_rt = 1'b0, EX_MemRead = 1'b0, ID_jump = 1'b0;
    logic        EX_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic        PCWrite, IF_IDCont, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold;
    logic [15:0] stall_cnt, flush_cnt;
    logic        timeout_err;
    logic [5:0]  ctrl_o;

    int n_vec = 0;
    int n_bad = 0;

    int m_stall = 0, m_flush = 0, m_waits = 0;
    bit m_wait = 0, m_to = 0;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, memread;
        logic [4:0] ex_rt;
        logic       jump, br, req, ready;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    assign ctrl_o = {PCWrite, IF_IDCont, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold};

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_uses_rt      (ID_uses_rt),
        .EX_MemRead      (EX_MemRead),
        .EX_rt           (EX_rt),
        .ID_jump         (ID_jump),
        .EX_branch_taken (EX_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .PCWrite         (PCWrite),
        .IF_IDCont       (IF_IDCont),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .ID_EX_Hold      (ID_EX_Hold),
        .EX_MEM_Hold     (EX_MEM_Hold),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .timeout_err     (timeout_err)
    );

    function automatic stim_t mk(int rs, int rt, bit uses, bit memread, int ex_rt,
                                 bit jump, bit br, bit req, bit ready);
        stim_t s;
        s.rs = 5'(rs);  s.rt = 5'(rt);  s.uses_rt = uses;  s.memread = memread;
        s.ex_rt = 5'(ex_rt);  s.jump = jump;  s.br = br;  s.req = req;  s.ready = ready;
        return s;
    endfunction

    function automatic bit m_lu(stim_t s);
        return s.memread && s.ex_rt != 0 && (s.ex_rt == s.rs || (s.uses_rt && s.ex_rt == s.rt));
    endfunction

    function automatic bit m_freeze(stim_t s);
        return m_to || (s.req && !s.ready);
    endfunction

    // Expected {PCWrite, IF_IDCont, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold}
    function automatic logic [5:0] model_ctrl(stim_t s);
        if (m_freeze(s)) return 6'b010011;
        if (s.br)        return 6'b101100;
        if (m_lu(s))     return 6'b010100;
        if (s.jump)      return 6'b101000;
        return 6'b100000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(stim_t s);
        ID_rs = s.rs;  ID_rt = s.rt;  ID_uses_rt = s.uses_rt;  EX_MemRead = s.memread;
        EX_rt = s.ex_rt;  ID_jump = s.jump;  EX_branch_taken = s.br;
        mem_req = s.req;  mem_ready = s.ready;
    endtask

    task automatic model_step(stim_t s);
        logic [5:0] c;
        c = model_ctrl(s);
        if (m_freeze(s) || (m_lu(s) && !s.br)) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (c[3] || c[2])                      m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        if (!m_to) begin
            if (!m_wait) begin
                if (s.req && !s.ready) begin
                    m_wait  = 1;
                    m_waits = 0;
                end
            end else if (s.ready)
                m_wait = 0;
            else begin
                m_waits++;
                if (m_waits >= MAX_WAIT) m_to = 1;
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(string name, stim_t s, logic [5:0] exp);
        apply(s);
        #2;
        chk({name, " ctrl"}, 32'(ctrl_o), 32'(exp));
        chk({name, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        chk({name, " flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        chk({name, " timeout_err"}, 32'(timeout_err), 32'(m_to));
        @(posedge clk);
        #1;
        model_step(s);
    endtask

    // Asserts reset between edges so the checks only hold for an asynchronous clear.
    task automatic do_reset(string name);
        reset = 1'b1;
        #1;
        chk({name, " reset ctrl"}, 32'(ctrl_o), 32'h20);
        chk({name, " reset stall_cnt"}, 32'(stall_cnt), 32'h0);
        chk({name, " reset flush_cnt"}, 32'(flush_cnt), 32'h0);
        chk({name, " reset timeout_err"}, 32'(timeout_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_stall = 0;  m_flush = 0;  m_waits = 0;  m_wait = 0;  m_to = 0;
    endtask

    initial begin
        stim_t idle, frz, lu;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        frz  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        lu   = mk(8, 0, 0, 1, 8, 0, 0, 0, 0);

        tbl.push_back('{"normal",     mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 6'b100000});
        tbl.push_back('{"lu_rs",      lu,                            6'b010100});
        tbl.push_back('{"lu_rt",      mk(3, 8, 1, 1, 8, 0, 0, 0, 0), 6'b010100});
        tbl.push_back('{"rt_unused",  mk(3, 8, 0, 1, 8, 0, 0, 0, 0), 6'b100000});
        tbl.push_back('{"reg_zero",   mk(0, 0, 1, 1, 0, 0, 0, 0, 0), 6'b100000});
        tbl.push_back('{"no_load",    mk(8, 8, 1, 0, 8, 0, 0, 0, 0), 6'b100000});
        tbl.push_back('{"branch",     mk(1, 2, 1, 0, 0, 0, 1, 0, 0), 6'b101100});
        tbl.push_back('{"br_lu",      mk(8, 0, 0, 1, 8, 0, 1, 0, 0), 6'b101100});
        tbl.push_back('{"jump",       mk(1, 2, 1, 0, 0, 1, 0, 0, 0), 6'b101000});
        tbl.push_back('{"jump_lu",    mk(8, 0, 0, 1, 8, 1, 0, 0, 0), 6'b010100});
        tbl.push_back('{"jump_after", mk(8, 0, 0, 0, 8, 1, 0, 0, 0), 6'b101000});
        tbl.push_back('{"br_jump",    mk(1, 2, 1, 0, 0, 1, 1, 0, 0), 6'b101100});
        tbl.push_back('{"mem_hit",    mk(1, 2, 1, 0, 0, 0, 0, 1, 1), 6'b100000});

        #1;
        do_reset("init");

        foreach (tbl[i]) cycle(tbl[i].name, tbl[i].s, tbl[i].exp);

        do_reset("lu_seq");
        cycle("lu_seq", lu, 6'b010100);
        chk("lu_seq stall 0->1", 32'(stall_cnt), 32'd1);

        do_reset("br_lu_seq");
        cycle("br_lu_seq", mk(8, 0, 0, 1, 8, 0, 1, 0, 0), 6'b101100);
        chk("br_lu_seq flush +1", 32'(flush_cnt), 32'd1);
        chk("br_lu_seq stall unchanged", 32'(stall_cnt), 32'd0);

        do_reset("memwait");
        for (int i = 0; i < 3; i++) cycle("memwait wait", frz, 6'b010011);
        cycle("memwait ready", mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 6'b100000);
        chk("memwait stall +3", 32'(stall_cnt), 32'd3);
        cycle("memwait run", idle, 6'b100000);

        do_reset("timeout");
        for (int i = 0; i < 4; i++) cycle("timeout wait", frz, 6'b010011);
        chk("timeout not yet", 32'(timeout_err), 32'd0);
        cycle("timeout last", frz, 6'b010011);
        chk("timeout set", 32'(timeout_err), 32'd1);
        for (int i = 0; i < 2; i++) cycle("timeout sticky", mk(0, 0, 0, 0, 0, 1, 1, 1, 1), 6'b010011);
        chk("timeout stall count", 32'(stall_cnt), 32'd7);
        do_reset("in_timeout");
        cycle("after timeout", idle, 6'b100000);

        do_reset("mid_wait pre");
        for (int i = 0; i < 2; i++) cycle("mid_wait", frz, 6'b010011);
        apply(frz);
        do_reset("mid_wait");
        cycle("mid_wait after", frz, 6'b010011);
        cycle("mid_wait release", mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 6'b100000);

        do_reset("sat");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        repeat (70000) @(posedge clk);
        #1;
        chk("sat flush_cnt", 32'(flush_cnt), 32'hFFFF);
        chk("sat stall_cnt", 32'(stall_cnt), 32'h0);

        do_reset("rand");
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.ex_rt   = 5'($urandom_range(0, 3));
            s.uses_rt = 1'($urandom_range(0, 1));
            s.memread = 1'($urandom_range(0, 1));
            s.jump    = ($urandom_range(0, 3) == 0);
            s.br      = ($urandom_range(0, 3) == 0);
            s.req     = ($urandom_range(0, 2) == 0);
            s.ready   = ($urandom_range(0, 3) != 0);
            cycle("rand", s, model_ctrl(s));
            if (m_to && $urandom_range(0, 3) == 0) do_reset("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
